// File: rtl/cac_fns4_codec.sv
// Crosstalk-avoidance codec for a 4-wire TSV bundle.
// The encoder maps a 3-bit word to a 4-bit Fibonacci-numeral (Zeckendorf) code.
// That code is XORed with 1010 so no wire pair ever carries the forbidden 0101 pattern.
// The encoder output is registered onto the TSVs.
// The decoder is purely combinational and also flags received words that are not legal codewords.
module cac_fns4_codec #(
  parameter int BLEN   = 3,
  parameter int TLEN   = 4,
  parameter int FNS_02 = 2,
  parameter int FNS_03 = 3,
  parameter int FNS_04 = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [BLEN-1:0] datain,
  output logic [TLEN-1:0] tsv,
  input  logic [TLEN-1:0] tsv_rx,
  output logic [BLEN-1:0] dataout,
  output logic            dataerr
);

  // XOR mask that turns "no adjacent ones" in the Zeckendorf word into
  // "no adjacent pair matching 0101" on the wires.
  localparam logic [TLEN-1:0] PATTERN = TLEN'(4'b1010);

  // Fibonacci weights, sized to the arithmetic width.
  localparam logic [TLEN-1:0] W2 = TLEN'(FNS_02);
  localparam logic [TLEN-1:0] W3 = TLEN'(FNS_03);
  localparam logic [TLEN-1:0] W4 = TLEN'(FNS_04);

  // Weighted sum of a Zeckendorf word; bit 0 carries an implicit weight of 1.
  function automatic logic [TLEN-1:0] fns_sum(input logic [TLEN-1:0] z);
    logic [TLEN-1:0] s;
    s = {{(TLEN-1){1'b0}}, z[0]};
    if (z[1]) s = s + W2;
    if (z[2]) s = s + W3;
    if (z[3]) s = s + W4;
    return s;
  endfunction

  logic [TLEN-1:0] rem;
  logic [TLEN-1:0] z_enc;
  logic [TLEN-1:0] enc_word;
  logic [TLEN-1:0] z_dec;

  // Greedy MSB-first Zeckendorf conversion, then pattern mapping.
  // Greedy selection is what guarantees no two adjacent ones in z_enc.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    rem   = TLEN'(datain);
    z_enc = '0;
    if (rem >= W4) begin
      z_enc[3] = 1'b1;
      rem      = rem - W4;
    end
    if (rem >= W3) begin
      z_enc[2] = 1'b1;
      rem      = rem - W3;
    end
    if (rem >= W2) begin
      z_enc[1] = 1'b1;
      rem      = rem - W2;
    end
    z_enc[0] = rem[0];
    enc_word = z_enc ^ PATTERN;
  end

  // TSV driver register; reset loads the encoding of 0 and wins over datain.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) tsv <= PATTERN;
    else       tsv <= enc_word;
  end

  // Combinational decoder: undo the mask, sum the weights, flag adjacent ones.
  // Illegal words can sum past 7; the sum is truncated to the data width.
  always_comb begin
    z_dec   = tsv_rx ^ PATTERN;
    dataout = BLEN'(fns_sum(z_dec));
    dataerr = |(z_dec[TLEN-1:1] & z_dec[TLEN-2:0]);
  end

endmodule

// File: tb/tb_cac_fns4_codec.sv
// Scoreboard bench for cac_fns4_codec.
// The driver pushes hand-computed expectations tagged with the cycle in which they become visible.
// The negedge monitor pops and compares them against the DUT outputs.
module tb_cac_fns4_codec;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] datain;
  logic [3:0] tsv;
  logic [3:0] tsv_rx;
  logic [2:0] dataout;
  logic       dataerr;

  logic       loop;
  logic [3:0] tsv_force;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    string      nm;
    bit         chk_tsv;
    logic [3:0] tsv;
    logic [2:0] dout;
    logic       derr;
  } exp_t;

  exp_t q[$];

  // Hand-written code table, datain -> tsv.
  logic [3:0] tbl [8] = '{4'b1010, 4'b1011, 4'b1000, 4'b1110,
                          4'b1111, 4'b0010, 4'b0011, 4'b0000};

  assign tsv_rx = loop ? tsv : tsv_force;

  cac_fns4_codec dut (
    .clock   (clock),
    .reset   (reset),
    .datain  (datain),
    .tsv     (tsv),
    .tsv_rx  (tsv_rx),
    .dataout (dataout),
    .dataerr (dataerr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: compare every expectation that is due in the current cycle.
  always @(negedge clock) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check({e.nm, "_stale"}, 4'(e.cyc), 4'(cyc));
      end else begin
        if (e.chk_tsv) begin
          check({e.nm, "_tsv"}, tsv, e.tsv);
          // Forbidden-pair check on the actual wires.
          check({e.nm, "_pattern"},
                4'({tsv[3:2] == 2'b01 || tsv[2:1] == 2'b10 || tsv[1:0] == 2'b01}),
                4'd0);
        end
        check({e.nm, "_dataout"}, 4'(dataout), 4'(e.dout));
        check({e.nm, "_dataerr"}, 4'(dataerr), 4'(e.derr));
      end
    end
  end

  // Drive one edge worth of stimulus; the result is visible in the next cycle.
  task automatic drive(input logic [2:0] d, input logic r, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    datain  = d;
    reset   = r;
    e.cyc     = cyc + 1;
    e.nm      = nm;
    e.chk_tsv = 1'b1;
    e.tsv     = r ? 4'b1010 : tbl[d];
    e.dout    = r ? 3'd0 : d;
    e.derr    = 1'b0;
    q.push_back(e);
  endtask

  // Force a raw word onto the decoder input, checked at the next negedge.
  task automatic force_rx(input logic [3:0] w, input logic [2:0] dout, input logic derr,
                          input string nm);
    exp_t e;
    @(negedge clock);
    #1;
    loop      = 1'b0;
    tsv_force = w;
    e.cyc     = cyc + 1;
    e.nm      = nm;
    e.chk_tsv = 1'b0;
    e.tsv     = 4'b0000;
    e.dout    = dout;
    e.derr    = derr;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    loop      = 1'b1;
    tsv_force = 4'b0000;
    reset     = 1'b1;
    datain    = 3'd7;
    // Reset edge with datain = 7 must still load the encoding of 0.
    e.cyc = 1; e.nm = "reset"; e.chk_tsv = 1'b1;
    e.tsv = 4'b1010; e.dout = 3'd0; e.derr = 1'b0;
    q.push_back(e);

    // Loopback sweep 0..99 truncated to 3 bits.
    for (int i = 0; i < 100; i++) drive(3'(i), 1'b0, "sweep");

    // Let the last sweep item be checked before touching tsv_rx.
    repeat (2) @(negedge clock);
    force_rx(4'b0101, 3'd3, 1'b1, "illegal_0101");
    force_rx(4'b0110, 3'd0, 1'b1, "illegal_0110");
    force_rx(4'b1111, 3'd4, 1'b0, "legal_1111");
    @(negedge clock);
    #1;
    loop = 1'b1;

    // Mid-stream reset.
    drive(3'd4, 1'b0, "enc4");
    drive(3'd5, 1'b1, "rst_mid");
    drive(3'd5, 1'b0, "resume");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clock);
    @(negedge clock);
    #1;
    while (q.size() != 0) begin
      e = q.pop_front();
      check({e.nm, "_timeout"}, 4'(q.size() + 1), 4'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
